// File: rtl/gt_frame_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gt_frame_pkg
// Purpose  : Shared symbol constants, abort codes and FSM state encoding for
//            the GT receive-side frame unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package gt_frame_pkg;

    localparam logic [7:0] K_SOF  = 8'h7E;
    localparam logic [7:0] K_MARK = 8'h5D;

    localparam logic [1:0] ERR_MARK  = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_TRUNC = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        DROP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_cnt16.sv
`default_nettype none
// ============================================================================
// Module   : sat_cnt16
// Purpose  : 16-bit event counter with increment enable, sticks at 0xFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module sat_cnt16 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= 16'd0;
        end else if (i_inc && (o_cnt != 16'hFFFF)) begin
            o_cnt <= o_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gt_frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : gt_frame_unpacker
// Purpose  : Parses marker-escaped frames from the GT rx user bus and emits
//            packed payload beats with keep/sof/eof plus abort reporting.
// Revision : 1.0 - initial release
// ============================================================================
module gt_frame_unpacker
    import gt_frame_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int MAX_LEN = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_resetdone,
    input  logic [8*LANES-1:0]       i_rx_data,
    input  logic [LANES-1:0]         i_rxcharisk,
    output logic [8*(LANES/2)-1:0]   o_data,
    output logic [LANES/2-1:0]       o_keep,
    output logic                     o_valid,
    output logic                     o_sof,
    output logic                     o_eof,
    output logic [7:0]               o_type,
    output logic [15:0]              o_len,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic [15:0]              o_frame_cnt,
    output logic [15:0]              o_err_cnt
);

    localparam int          S     = LANES / 2;
    localparam int          W     = 8 * LANES;
    localparam logic [15:0] c_S   = 16'(S);
    localparam logic [15:0] c_MAX = 16'(MAX_LEN);

    state_t        r_state;
    logic [2:0]    r_hidx;
    logic [7:0]    r_type;
    logic [15:0]   r_len;
    logic [15:0]   r_rem;
    logic          r_first;

    logic          w_acc;
    logic [7:0]    w_mark [S];
    logic [7:0]    w_byte [S];
    logic [2:0]    w_hbase;
    logic          w_hdr_bad, w_hdr_last, w_len_bad, w_hdr_word;
    logic [7:0]    w_type, w_len_hi, w_len_lo;
    logic [15:0]   w_hlen, w_nsym;
    logic          w_pay_bad, w_last;
    logic [8*S-1:0] w_pdata;
    logic [S-1:0]  w_pkeep;
    logic          w_abort, w_hdr_ok, w_emit, w_done;
    logic [1:0]    w_code;

    always_comb begin
        w_acc = i_resetdone && (i_rxcharisk == '0);
        for (int k = 0; k < S; k++) begin
            w_mark[k] = i_rx_data[W-1-16*k -: 8];
            w_byte[k] = i_rx_data[W-9-16*k -: 8];
        end
    end

    // Header symbols are tracked by index so one path serves every lane width.
    always_comb begin
        w_hbase   = (r_state == IDLE) ? 3'd0 : r_hidx;
        w_hdr_bad = 1'b0;
        w_type    = r_type;
        w_len_hi  = r_len[15:8];
        w_len_lo  = r_len[7:0];
        for (int k = 0; k < S; k++) begin
            if (int'(w_hbase) + k == 0) begin
                w_type = w_byte[k];
            end else begin
                if (w_mark[k] != K_MARK) w_hdr_bad = 1'b1;
                if (int'(w_hbase) + k == 1) w_len_hi = w_byte[k];
                if (int'(w_hbase) + k == 2) w_len_lo = w_byte[k];
            end
        end
        w_hlen     = {w_len_hi, w_len_lo};
        w_hdr_last = ((w_hbase + 3'(S)) == 3'd4);
        w_len_bad  = (w_hlen == 16'd0) || (w_hlen > c_MAX);
    end

    always_comb begin
        w_nsym    = (r_rem < c_S) ? r_rem : c_S;
        w_last    = (r_rem <= c_S);
        w_pay_bad = 1'b0;
        w_pdata   = '0;
        w_pkeep   = '0;
        for (int k = 0; k < S; k++) begin
            if (16'(k) < w_nsym) begin
                if (w_mark[k] != K_MARK) w_pay_bad = 1'b1;
                w_pdata[8*(S-1-k) +: 8] = w_byte[k];
                w_pkeep[S-1-k]          = 1'b1;
            end
        end
    end

    always_comb begin
        w_abort    = 1'b0;
        w_code     = 2'd0;
        w_hdr_ok   = 1'b0;
        w_emit     = 1'b0;
        w_done     = 1'b0;
        w_hdr_word = ((r_state == IDLE) && w_acc && (w_mark[0] == K_SOF)) ||
                     ((r_state == HDR) && w_acc);
        if (((r_state == HDR) || (r_state == PAY)) && !w_acc) begin
            w_abort = 1'b1;
            w_code  = ERR_TRUNC;
        end else if (w_hdr_word) begin
            if (w_hdr_bad) begin
                w_abort = 1'b1;
                w_code  = ERR_MARK;
            end else if (w_hdr_last && w_len_bad) begin
                w_abort = 1'b1;
                w_code  = ERR_LEN;
            end else begin
                w_hdr_ok = w_hdr_last;
            end
        end else if (r_state == PAY) begin
            if (w_pay_bad) begin
                w_abort = 1'b1;
                w_code  = ERR_MARK;
            end else begin
                w_emit = 1'b1;
                w_done = w_last;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_hidx     <= 3'd0;
            r_type     <= 8'd0;
            r_len      <= 16'd0;
            r_rem      <= 16'd0;
            r_first    <= 1'b0;
            o_data     <= '0;
            o_keep     <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_type     <= 8'd0;
            o_len      <= 16'd0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_err   <= 1'b0;
            if (w_abort) begin
                o_err      <= 1'b1;
                o_err_code <= w_code;
                // An idle word already meets the drop exit condition.
                r_state    <= w_acc ? DROP : IDLE;
            end else if (w_hdr_word) begin
                r_type  <= w_type;
                r_len   <= w_hlen;
                r_rem   <= w_hlen;
                r_hidx  <= w_hbase + 3'(S);
                r_first <= 1'b1;
                r_state <= w_hdr_ok ? PAY : HDR;
            end else if (w_emit) begin
                o_valid <= 1'b1;
                o_data  <= w_pdata;
                o_keep  <= w_pkeep;
                o_sof   <= r_first;
                o_eof   <= w_done;
                if (r_first) begin
                    o_type <= r_type;
                    o_len  <= r_len;
                end
                r_first <= 1'b0;
                r_rem   <= r_rem - w_nsym;
                if (w_done) r_state <= IDLE;
            end else if ((r_state == DROP) && !w_acc) begin
                r_state <= IDLE;
            end
        end
    end

    sat_cnt16 u_frame_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_done),
        .o_cnt   (o_frame_cnt)
    );

    sat_cnt16 u_err_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_abort),
        .o_cnt   (o_err_cnt)
    );

endmodule
`default_nettype wire

// File: doc/gt_frame_unpacker.md
# gt_frame_unpacker

Parametrised receive-side deframer between the GT receiver user interface and the async FIFO feeding the UART path. It parses marker-escaped frames (0x7E start, type, 16-bit length, payload symbols of 0x5D + data byte) from a 2/4/8-byte-wide `rx_data` bus. It emits packed payload words with per-symbol keep, sof and eof flags, and reports malformed frames with an error code. Saturating frame and error counters are provided.

## Interface
- `LANES`, 8, bytes per rx word; legal values are 2, 4 and 8. S = LANES/2 symbols per word.
- `MAX_LEN`, 1024, largest accepted payload length in symbols (bytes).
- `i_clk` in 1: rxusrclk domain. Single clock; every register is clocked by it.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_resetdone` in 1: GT reset done. When low, the block is forced to IDLE.
- `i_rx_data` in 8*LANES: rx word; byte 0 is bits [8*LANES-1 -: 8] (MSB-first).
- `i_rxcharisk` in LANES: K flags. Any bit set marks the word as idle.
- `o_data` out 8*S: payload bytes; symbol 0 is in the MSBs.
- `o_keep` out S: valid symbols, MSB-aligned; keep[S-1] is symbol 0.
- `o_valid` out 1: o_data/o_keep valid this cycle.
- `o_sof`, `o_eof` out 1: first and last payload beat of a frame.
- `o_type` out 8, `o_len` out 16: header fields. Both are held from the sof beat until the next header.
- `o_err` out 1: one-cycle abort pulse. `o_err_code` out 2: 1 = bad marker, 2 = bad length, 3 = truncated.
- `o_frame_cnt`, `o_err_cnt` out 16: good frames and aborts; both saturate at 0xFFFF.

## Operation
- Word accepted: `i_resetdone` = 1 and `i_rxcharisk` = 0. Any other word is idle.
- Header: 4 symbols (7E,type) (5D,len_hi) (5D,len_lo) (5D,00), always word-aligned.
  - LANES=8: header is 1 word. LANES=4: 2 words. LANES=2: 4 words.
- Payload: exactly len symbols (5D,byte), starting on the word after the header. The last word is padded; pad symbols are ignored and are not checked.
- States:
  - IDLE: an accepted word with byte 0 = 0x7E → HDR. For LANES=8, the header is checked in the same word and the state goes directly to PAY.
  - HDR: collect the remaining header words. Every marker must be 0x5D; otherwise abort with code 1. len = 0 or len > MAX_LEN → abort with code 2. Valid header → PAY.
  - PAY: per accepted word, emit min(S, remaining) symbols. Any counted symbol with marker ≠ 0x5D → abort with code 1. When remaining reaches 0: eof, frame_cnt++, → IDLE.
  - DROP: discard words until an idle word arrives, then → IDLE.
- Abort: o_err pulse with code, err_cnt++, → DROP. The data in the word that caused the abort is not emitted, and no eof is produced; downstream discards the open frame.
- An idle word inside HDR or PAY aborts with code 3 and goes to IDLE (the idle word already satisfies DROP's exit condition).
- `i_resetdone` falling mid-frame: abort with code 3 and go to IDLE. `i_resetdone` falling in IDLE or DROP: go to IDLE silently.
- Back-to-back frames: a 7E word immediately after the eof word is accepted.
- Errors other than the header checks are evaluated on the counted symbols only.

## Timing
- Reset values: o_data=0, o_keep=0, o_valid=0, o_sof=0, o_eof=0, o_type=0, o_len=0, o_err=0, o_err_code=0, both counters=0, state IDLE.
- All outputs are registered. Latency: input word sampled at edge n → output at edge n+1.
- No backpressure; one output beat per accepted payload word.
- o_sof and o_eof both assert on a single beat when len ≤ S.
- A counter update appears at n+1, aligned with o_eof or o_err.
- o_keep is all ones except on the eof beat, where it has ((len-1) mod S)+1 MSBs set.

## Structure
- Package `gt_frame_pkg` holds:
  - K_SOF = 8'h7E, K_MARK = 8'h5D;
  - error code localparams ERR_MARK = 1, ERR_LEN = 2, ERR_TRUNC = 3;
  - the state enum {IDLE, HDR, PAY, DROP}.
- One sub-module: `sat_cnt16` (increment-enable, saturating at 0xFFFF), instantiated twice for the two counters.

## Test plan
- LANES=8, type 01, len 29 → 8 beats. Beat 0 has sof; beats 0–6 have keep 4'hF; beat 7 has keep 4'b1000 and eof. o_type=01, o_len=29, frame_cnt=1.
- Back-to-back frames len 30 (type 02) then len 31 (type 03), no idle between them → eof keeps 4'b1100 and 4'b1110; frame_cnt=2.
- Payload marker 0x5C in beat 3 of a len-16 frame → o_err with code 1 one cycle later, no eof, err_cnt=1. Following words are dropped until idle; the next frame is accepted.
- Header len=0, and separately len=1025 → code 2 each time; no o_valid.
- Idle word (charisk=8'hFF) mid-payload, and `i_resetdone` low mid-payload → code 3, state IDLE.
- Rerun with LANES=2 and LANES=4 and a len-5 frame → 5 beats with keep 1 (LANES=2), or 3 beats with eof keep 2'b10 (LANES=4). Assert `i_rst_n` mid-frame → all outputs return to 0 immediately.
